// File: rtl/cmd_seq_pkg.sv
// Shared encodings for the command sequencer: FSM states, trap causes and size decode.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_RETIRE = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } trap_cause_t;

    localparam logic [1:0] SIZE_ILLEGAL = 2'd0;

    // Byte length of a command of the given word count.
    function automatic logic [31:0] size_bytes(input logic [1:0] size, input int unsigned word_bytes);
        return 32'(size) * 32'(word_bytes);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// 8-bit executor watchdog: cleared at command start, counts while enabled.
module seq_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Flags the enabled cycle whose increment would reach LIMIT, so the
    // owner can leave on exactly the LIMIT-th idle cycle.
    assign expired = enable && ((9'(count_reg) + 9'd1) >= 9'(LIMIT));

endmodule

// File: rtl/cmd_sequencer.sv
// Program-counter owner that walks each command through fetch, decode, execute and retire.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        WORD_BYTES = 4,
    parameter int unsigned        TIMEOUT    = 255,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic [1:0]        cmd_size,
    output logic              exe_start,
    input  logic              exe_done,
    input  logic              exe_jmp,
    input  logic [ADDR_W-1:0] exe_jmp_offset,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  retired_cnt
);

    seq_state_t        state_reg, state_next;
    trap_cause_t       trap_cause_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] offset_reg;
    logic [1:0]        size_reg;
    logic              jmp_reg;
    logic              step_latch_reg;
    logic              fetch_req_reg;
    logic              exe_start_reg;
    logic              halted_reg;
    logic [CNT_W-1:0]  retired_cnt_reg;

    logic wd_clear, wd_enable, wd_expired;

    assign wd_clear  = (state_reg == S_EXEC);
    assign wd_enable = (state_reg == S_WAIT) && !exe_done;

    seq_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run || step) state_next = S_FETCH;
            S_FETCH:  if (fetch_ack) state_next = S_DECODE;
            S_DECODE: state_next = (cmd_size == SIZE_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC:   state_next = S_WAIT;
            S_WAIT: begin
                if (exe_done)        state_next = S_RETIRE;
                else if (wd_expired) state_next = S_TRAP;
            end
            S_RETIRE: state_next = (run && !step_latch_reg) ? S_FETCH : S_IDLE;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            trap_cause_reg  <= TRAP_NONE;
            pc_reg          <= RESET_PC;
            offset_reg      <= '0;
            size_reg        <= '0;
            jmp_reg         <= 1'b0;
            step_latch_reg  <= 1'b0;
            fetch_req_reg   <= 1'b0;
            exe_start_reg   <= 1'b0;
            halted_reg      <= 1'b1;
            retired_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            // Strobes follow the state being entered so they line up with it.
            fetch_req_reg <= (state_next == S_FETCH);
            exe_start_reg <= (state_next == S_EXEC);
            halted_reg    <= (state_next == S_IDLE) || (state_next == S_TRAP);

            case (state_reg)
                S_IDLE: step_latch_reg <= step && !run;
                S_DECODE: begin
                    size_reg <= cmd_size;
                    if (cmd_size == SIZE_ILLEGAL) trap_cause_reg <= TRAP_ILLEGAL;
                end
                S_WAIT: begin
                    if (exe_done) begin
                        jmp_reg    <= exe_jmp;
                        offset_reg <= exe_jmp_offset;
                    end else if (wd_expired) begin
                        trap_cause_reg <= TRAP_TIMEOUT;
                    end
                end
                S_RETIRE: begin
                    pc_reg <= jmp_reg ? (pc_reg + offset_reg)
                                      : (pc_reg + ADDR_W'(size_bytes(size_reg, WORD_BYTES)));
                    retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
                    step_latch_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign fetch_req   = fetch_req_reg;
    assign fetch_addr  = pc_reg;
    assign exe_start   = exe_start_reg;
    assign pc          = pc_reg;
    assign state       = state_reg;
    assign halted      = halted_reg;
    assign trap_cause  = trap_cause_reg;
    assign retired_cnt = retired_cnt_reg;

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Control sequencer for the command-processor datapath. It owns the program counter and steps each command through fetch, decode, execute and retire, handshaking with the fetcher and the executor. It applies sequential advance or jump redirection and traps on illegal sizes or executor timeouts. It sits between the fetcher/decoder/executor trio and the board-level run/step controls.

## Interface
- ADDR_W, 32, program-counter and fetch-address width
- RESET_PC, 0, PC value loaded on reset
- WORD_BYTES, 4, bytes per command word; PC advance = cmd_size × WORD_BYTES
- TIMEOUT, 255, max cycles in WAIT before trap; 8-bit counter
- CNT_W, 16, retired-command counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; continuous execution while high
- step  in  1  one-cycle pulse; execute exactly one command when run low
- fetch_req  out  1  request command at fetch_addr
- fetch_addr  out  ADDR_W  byte address of the command (= pc)
- fetch_ack  in  1  fetcher has presented command words/code
- cmd_size  in  2  decoder output, words 1..3; 0 = illegal
- exe_start  out  1  one-cycle pulse, executor begins
- exe_done  in  1  executor ready_flag
- exe_jmp  in  1  jump taken; valid with exe_done
- exe_jmp_offset  in  ADDR_W  signed byte offset from current pc; valid with exe_done
- pc  out  ADDR_W  current command address
- state  out  3  current FSM state (debug)
- halted  out  1  high in IDLE or TRAP
- trap_cause  out  2  00 none, 01 illegal size, 10 timeout; sticky
- retired_cnt  out  CNT_W  commands retired, wraps

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT=4, RETIRE=5, TRAP=6.
- IDLE: leave to FETCH when run=1 or step=1; a step pulse arms a one-command latch.
- FETCH: fetch_req=1 and fetch_addr=pc held until fetch_ack=1. Then go to DECODE.
- DECODE: sample cmd_size into a register. If 0, set trap_cause=01 and go to TRAP; otherwise go to EXEC.
- EXEC: exe_start=1 for exactly this cycle, then go to WAIT. The watchdog clears here.
- WAIT: sample exe_done each cycle. On exe_done, latch exe_jmp/exe_jmp_offset and go to RETIRE. Otherwise the watchdog increments; when it reaches TIMEOUT, set trap_cause=10 and go to TRAP.
- RETIRE: pc ← exe_jmp ? pc + offset : pc + size×WORD_BYTES, modulo 2^ADDR_W. retired_cnt increments and wraps. Next state is FETCH if run=1 and the step latch is clear, else IDLE; the step latch clears.
- TRAP: absorbing; run and step are ignored. Exit only via rst. pc holds the faulting command address.
- run deasserted mid-command: the current command completes through RETIRE, then IDLE.
- step while run=1, or outside IDLE: ignored.
- exe_done during EXEC: ignored (not sampled).
- Jump offset 0: legal self-loop.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, halted=1, fetch_req=0, exe_start=0, trap_cause=00, retired_cnt=0, fetch_addr=RESET_PC.
- All outputs are registered or decoded from registered state; no combinational input-to-output path except none.
- Minimum command period is 5 cycles (FETCH, DECODE, EXEC, WAIT, RETIRE), with fetch_ack and exe_done asserted on first opportunity.
- Updated pc is visible the cycle after RETIRE, together with the next fetch_req.
- rst has priority over every transition; reset mid-command abandons it with no retire.

## Structure
- Package cmd_seq_pkg holds the state encoding constants, the trap_cause codes, and the illegal-size code 0.
- Sub-module seq_watchdog holds the 8-bit cycle counter with clear/enable and an expired flag. Everything else lives in cmd_sequencer.

## Test plan
- Reset, run=1, cmd_size=1, instant acks, exe_jmp=0 → fetch_addr 0,4,8,… every 5 cycles; retired_cnt increments each command.
- run=0, single step pulse, cmd_size=3 → exactly one exe_start; pc=12; state returns to IDLE; a second step while busy is ignored.
- exe_jmp=1, offset=-8 at pc=16 → next fetch_addr=8; offset 0 → same address refetched.
- cmd_size=0 at pc=4 → trap_cause=01, state=TRAP, pc=4, no exe_start; run/step ignored until rst.
- exe_done withheld → trap_cause=10 exactly TIMEOUT cycles after entering WAIT.
- rst asserted in WAIT → next cycle all outputs at reset values; retired_cnt unchanged from 0; pc=RESET_PC=0xFFFFFFFC with size 1 wraps to 0.
